// File: rtl/bcd2bin.sv
// Packed-BCD to binary converter using reverse double-dabble (shift right, then -3 on digits >= 8).
// One init pulse starts a fixed-length conversion; a one-cycle done pulse presents result/err.
module bcd2bin #(
    parameter int N_DIG = 5,
    parameter int W_BIN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [4*N_DIG-1:0] A,
    output logic [W_BIN-1:0]   result,
    output logic               err,
    output logic               busy,
    output logic               done
);
    localparam int BW = 4 * N_DIG;
    localparam int CW = $clog2(W_BIN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ADJ, FIN} state_t;

    state_t              state_q, state_d;
    logic [BW+W_BIN-1:0] sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                inv_q, inv_d;
    logic [W_BIN-1:0]    result_q, result_d;
    logic                err_q, err_d;

    logic [BW-1:0]       bcd_adj;
    logic [N_DIG-1:0]    dig_bad;

    // Per-digit correction of the shift register's BCD field, and input digit validity.
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        logic [3:0] dig;
        assign dig                = sr_q[W_BIN + 4*gi +: 4];
        assign bcd_adj[4*gi +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
        assign dig_bad[gi]        = (A[4*gi +: 4] > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            inv_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (init) begin
                    sr_d    = {A, {W_BIN{1'b0}}};
                    cnt_d   = CW'(W_BIN);
                    inv_d   = |dig_bad;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d    = sr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                state_d = ADJ;
            end
            ADJ: begin
                sr_d = {bcd_adj, sr_q[W_BIN-1:0]};
                if (cnt_q == '0) begin
                    state_d = FIN;
                    // Invalid input dominates; leftover BCD after all shifts means overflow.
                    if (inv_q) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end else if (bcd_adj != '0) begin
                        result_d = '1;
                        err_d    = 1'b1;
                    end else begin
                        result_d = sr_q[W_BIN-1:0];
                        err_d    = 1'b0;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
endmodule

// File: tb/tb_bcd2bin.sv
// Directed and model-checked bench for bcd2bin: latency, overflow, invalid digits,
// init-while-busy, mid-conversion reset, init held high, random BCD and round-trip sweeps.
module tb_bcd2bin;
    logic        clk;
    logic        rst;
    logic        init;
    logic [19:0] A;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    bcd2bin #(.N_DIG(5), .W_BIN(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .A      (A),
        .result (result),
        .err    (err),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal interpretation of the BCD word, independent of the shift algorithm.
    function automatic void model(input logic [19:0] a, output logic [15:0] r, output logic e);
        int  v;
        bit  bad;
        int  d;
        v   = 0;
        bad = 0;
        for (int k = 4; k >= 0; k--) begin
            d = int'(a[4*k +: 4]);
            if (d > 9) bad = 1;
            v = v * 10 + d;
        end
        if (bad) begin
            r = 16'h0000; e = 1'b1;
        end else if (v > 65535) begin
            r = 16'hFFFF; e = 1'b1;
        end else begin
            r = v[15:0];  e = 1'b0;
        end
    endfunction

    function automatic logic [19:0] to_bcd(input int b);
        logic [19:0] w;
        int          v;
        v = b;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            w[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return w;
    endfunction

    task automatic run_conv(input string tag, input logic [19:0] a,
                            input logic [15:0] er, input logic ee);
        int   n;
        logic busy_all;
        @(negedge clk);
        A    = a;
        init = 1'b1;
        @(negedge clk);
        init     = 1'b0;
        A        = ~a;
        n        = 0;
        busy_all = busy;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (!busy) busy_all = 1'b0;
        end
        $display("conv %s A=%05h result=%04h err=%0d cycles=%0d", tag, a, result, err, n);
        chk({tag, ".lat"},  32'(n), 32'd32);
        chk({tag, ".res"},  32'(result), 32'(er));
        chk({tag, ".err"},  32'(err), 32'(ee));
        chk({tag, ".busy"}, 32'(busy_all), 32'd1);
        @(negedge clk);
        chk({tag, ".drop"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int          n;
        logic        busy_all;
        logic        saw_done;
        logic [19:0] a;
        logic [15:0] er;
        logic        ee;

        rst  = 1'b1;
        init = 1'b0;
        A    = '0;
        repeat (2) @(negedge clk);
        chk("reset.out", 32'({result, err, busy, done}), 32'd0);
        rst = 1'b0;

        // init re-pulsed mid-conversion with a different A must be ignored
        @(negedge clk);
        A    = 20'h12345;
        init = 1'b1;
        @(negedge clk);
        init     = 1'b0;
        n        = 0;
        busy_all = busy;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                A    = 20'h99999;
                init = 1'b1;
            end else begin
                init = 1'b0;
            end
            if (!busy) busy_all = 1'b0;
        end
        init = 1'b0;
        $display("conv repulse A=12345 result=%04h err=%0d cycles=%0d", result, err, n);
        chk("repulse.lat",  32'(n), 32'd32);
        chk("repulse.res",  32'(result), 32'h3039);
        chk("repulse.err",  32'(err), 32'd0);
        chk("repulse.busy", 32'(busy_all), 32'd1);
        @(negedge clk);
        chk("repulse.drop", 32'({done, busy}), 32'd0);

        // reset mid-conversion aborts immediately without a done pulse
        A    = 20'h65535;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        $display("abort rst mid-conversion result=%04h err=%0d busy=%0d done=%0d", result, err, busy, done);
        chk("abort.out", 32'({result, err, busy, done}), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort.no_done", 32'(saw_done), 32'd0);

        run_conv("x00042", 20'h00042, 16'h002A, 1'b0);
        run_conv("x12345", 20'h12345, 16'h3039, 1'b0);
        run_conv("x65535", 20'h65535, 16'hFFFF, 1'b0);
        run_conv("x00000", 20'h00000, 16'h0000, 1'b0);
        run_conv("x65536", 20'h65536, 16'hFFFF, 1'b1);
        run_conv("x99999", 20'h99999, 16'hFFFF, 1'b1);
        run_conv("x0A123", 20'h0A123, 16'h0000, 1'b1);
        run_conv("x00009", 20'h00009, 16'h0009, 1'b0);
        run_conv("x00010", 20'h00010, 16'h000A, 1'b0);
        run_conv("x10000", 20'h10000, 16'h2710, 1'b0);
        run_conv("x9000F", 20'h9000F, 16'h0000, 1'b1);

        // init held high: conversions run back to back, one every 34 cycles
        @(negedge clk);
        A    = 20'h00100;
        init = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("held.first", 32'(n), 32'd32);
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        init = 1'b0;
        $display("conv held A=00100 result=%04h err=%0d gap=%0d", result, err, n + 1);
        chk("held.gap", 32'(n + 1), 32'd34);
        chk("held.res", 32'(result), 32'h0064);
        @(negedge clk);
        @(negedge clk);
        chk("held.idle", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 5; k++) a[4*k +: 4] = 4'($urandom_range(0, 9));
            if (i == 15) a[11:8] = 4'hC;
            model(a, er, ee);
            run_conv($sformatf("rnd%0d", i), a, er, ee);
        end

        for (int i = 0; i < 16; i++) begin
            n = (i == 0) ? 65535 : int'($urandom_range(0, 65535));
            run_conv($sformatf("trip%0d", i), to_bcd(n), 16'(n), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
